// File: rtl/seq_scan_if.sv
// seq_scan_if: word-in / result-out handshake bundle for seq_scan_ctrl.
//   word_valid/word_ready/word_data   : producer hands one WIDTH-bit word
//   done_valid/done_ready             : consumer takes the scan results
//   match_count/first_pos/match_found : scan results, stable while done_valid
// master = producer/consumer side, slave = controller side.
interface seq_scan_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) ();

    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;
    logic             done_valid;
    logic             done_ready;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] first_pos;
    logic             match_found;

    modport master (
        output word_valid, word_data, done_ready,
        input  word_ready, done_valid, match_count, first_pos, match_found
    );

    modport slave (
        input  word_valid, word_data, done_ready,
        output word_ready, done_valid, match_count, first_pos, match_found
    );

endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: runs one WIDTH-bit word MSB-first through an external
// "1011" Moore detector and reports match count, first-match position
// and a found flag.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : seq_scan_if slave (word handshake in, results out)
//   det_clear_o  : detector reset, high for the single CLEAR cycle
//   det_bit_o    : detector serial input, 0 outside SHIFT
//   det_hit_i    : detector output, reflects the bit sent one cycle earlier
module seq_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_scan_if.slave  bus,
    output logic       det_clear_o,
    output logic       det_bit_o,
    input  logic       det_hit_i
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             found_q, found_d;
    logic             word_ready_q, word_ready_d;
    logic             det_clear_q, det_clear_d;
    logic             det_bit_q, det_bit_d;
    logic             done_valid_q, done_valid_d;
    logic             hit_c;
    logic [CNT_W-1:0] hit_pos_c;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            first_q      <= '0;
            found_q      <= 1'b0;
            word_ready_q <= 1'b1;
            det_clear_q  <= 1'b0;
            det_bit_q    <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            first_q      <= first_d;
            found_q      <= found_d;
            word_ready_q <= word_ready_d;
            det_clear_q  <= det_clear_d;
            det_bit_q    <= det_bit_d;
            done_valid_q <= done_valid_d;
        end
    end

    // Next-state, datapath and next output values
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        count_d      = count_q;
        first_d      = first_q;
        found_d      = found_q;
        word_ready_d = 1'b0;
        det_clear_d  = 1'b0;
        det_bit_d    = 1'b0;
        done_valid_d = 1'b0;

        // det_hit lags det_bit by one cycle: the first SHIFT cycle still shows
        // the cleared detector, and DRAIN shows the result of the last bit.
        hit_c = det_hit_i &&
                (((state_q == S_SHIFT) && (idx_q != '0)) || (state_q == S_DRAIN));
        hit_pos_c = (state_q == S_DRAIN) ? CNT_W'(WIDTH - 1)
                                         : CNT_W'(idx_q - IDX_W'(1));

        case (state_q)
            S_IDLE: begin
                if (bus.word_valid) begin
                    shreg_d = bus.word_data;
                    count_d = '0;
                    first_d = '0;
                    found_d = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Match bookkeeping; first_pos only latches the first hit, count saturates
        if (hit_c) begin
            if (!found_q) begin
                first_d = hit_pos_c;
            end
            found_d = 1'b1;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // Outputs are registered from the next state so they never glitch
        word_ready_d = (state_d == S_IDLE);
        det_clear_d  = (state_d == S_CLEAR);
        det_bit_d    = (state_d == S_SHIFT) && shreg_d[WIDTH-1];
        done_valid_d = (state_d == S_DONE);
    end

    assign bus.word_ready  = word_ready_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.match_count = count_q;
    assign bus.first_pos   = first_q;
    assign bus.match_found = found_q;
    assign det_clear_o     = det_clear_q;
    assign det_bit_o       = det_bit_q;

endmodule
